// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: shared opcodes, command layout and FSM states for alu_cmd_scheduler
package alu_sched_pkg;
  localparam logic [2:0] OP_CAS = 3'b111;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] FLAG_REG = 3'd7;
  typedef struct packed {
    logic [2:0] op;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [2:0] a3;
  } cmd_t;
  typedef enum logic [1:0] {IDLE, EXEC, WB, CAS_FLAG} state_t;
endpackage

// File: rtl/alu_cmd_scheduler_if.sv
// alu_cmd_scheduler_if: requester, ALU and response bundle; scheduler uses the slave modport
interface alu_cmd_scheduler_if #(parameter int NUM_REQ = 4, parameter int ID_W = $clog2(NUM_REQ));
  logic [NUM_REQ-1:0] req_valid, req_ready;
  logic [NUM_REQ*12-1:0] req_cmd;
  logic [2:0] alu_op_code;
  logic [31:0] data_a, data_b, y, rsp_data;
  logic O, C, Z, N, rsp_valid, rsp_cas_ok, busy;
  logic [ID_W-1:0] rsp_id;
  logic [3:0] rsp_flags;
  modport master (output req_valid, req_cmd, y, O, C, Z, N,
                  input req_ready, alu_op_code, data_a, data_b, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_cas_ok, busy);
  modport slave (input req_valid, req_cmd, y, O, C, Z, N,
                 output req_ready, alu_op_code, data_a, data_b, rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_cas_ok, busy);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request after ptr; one-hot grant plus index
module rr_arbiter #(parameter int NUM_REQ = 4, parameter int ID_W = $clog2(NUM_REQ)) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);
  logic [ID_W-1:0] j;
  // Walk from lowest to highest priority so the nearest requester after ptr wins last
  always_comb begin
    grant = '0;
    idx = '0;
    j = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (en && req[j]) begin
        grant = NUM_REQ'(1) << j;
        idx = j;
      end
    end
  end
endmodule

// File: rtl/alu_cmd_scheduler.sv
// alu_cmd_scheduler: owns the 8x32 register file and time-shares one ALU among requesters.
// Define ALU_SCHED_PERF_EN to add saturating perf_done / perf_cas_fail counters.
module alu_cmd_scheduler import alu_sched_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic rst,
  alu_cmd_scheduler_if.slave bus
`ifdef ALU_SCHED_PERF_EN
  ,
  output logic [31:0] perf_done,
  output logic [15:0] perf_cas_fail
`endif
);
  state_t state;
  cmd_t cmd, nxt;
  logic [ID_W-1:0] id, rr_ptr, gidx;
  logic [NUM_REQ-1:0] grant;
  logic [31:0] r [8];
  logic cas, z;
  assign cas = cmd.op == OP_CAS;
  assign z = bus.rsp_flags[1];
  assign bus.req_ready = grant;
  assign bus.busy = state != IDLE;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req(bus.req_valid), .en(state == IDLE && !rst), .ptr(rr_ptr), .grant(grant), .idx(gidx)
  );
  always_comb begin
    nxt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      nxt = gidx == ID_W'(i) ? cmd_t'(bus.req_cmd[12*i +: 12]) : nxt;
  end
  // rsp_data/rsp_flags double as the EXEC capture of y and {O,C,Z,N}
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cmd <= '0;
      id <= '0;
      rr_ptr <= ID_W'(NUM_REQ - 1);
      for (int i = 0; i < 8; i++) r[i] <= '0;
      bus.alu_op_code <= '0;
      bus.data_a <= '0;
      bus.data_b <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id <= '0;
      bus.rsp_data <= '0;
      bus.rsp_flags <= '0;
      bus.rsp_cas_ok <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|grant) begin
          cmd <= nxt;
          id <= gidx;
          rr_ptr <= gidx;
          state <= EXEC;
          bus.alu_op_code <= nxt.op == OP_CAS ? OP_SUB : nxt.op;
          bus.data_a <= r[nxt.a1];
          bus.data_b <= r[nxt.op == OP_CAS ? nxt.a3 : nxt.a2];
        end
        EXEC: begin
          bus.alu_op_code <= '0;
          bus.data_a <= '0;
          bus.data_b <= '0;
          bus.rsp_valid <= !cas;
          bus.rsp_id <= id;
          bus.rsp_data <= bus.y;
          bus.rsp_flags <= {bus.O, bus.C, bus.Z, bus.N};
          bus.rsp_cas_ok <= 1'b0;
          state <= WB;
        end
        WB: if (!cas) begin
          r[cmd.a3] <= bus.rsp_data;
          bus.rsp_valid <= 1'b0;
          state <= IDLE;
        end else begin
          if (z) r[cmd.a1] <= r[cmd.a2];
          else r[cmd.a3] <= r[cmd.a1];
          bus.rsp_valid <= 1'b1;
          bus.rsp_data <= z ? r[cmd.a2] : r[cmd.a1];
          bus.rsp_cas_ok <= z;
          state <= CAS_FLAG;
        end
        CAS_FLAG: begin
          r[FLAG_REG] <= {31'b0, z};
          bus.rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
`ifdef ALU_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      perf_done <= '0;
      perf_cas_fail <= '0;
    end else if (bus.rsp_valid) begin
      if (~&perf_done) perf_done <= perf_done + 32'd1;
      if (state == CAS_FLAG && !bus.rsp_cas_ok && ~&perf_cas_fail) perf_cas_fail <= perf_cas_fail + 16'd1;
    end
`endif
endmodule

// File: tb/tb_alu_cmd_scheduler.sv
// tb_alu_cmd_scheduler: directed stimulus with a transaction-level register-file model checked every cycle
module tb_alu_cmd_scheduler;
  localparam int NUM_REQ = 4;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, ORR = 3'd3, XOR = 3'd4, SHL = 3'd5, INC = 3'd6, CAS = 3'd7;
  logic clk = 1'b0, rst = 1'b1;
  int checks = 0, errors = 0;
  int lat, gk;
  logic [31:0] rd;
  logic rok;
  logic [3:0] gv;
  int order [5];
  int n;
  alu_cmd_scheduler_if #(.NUM_REQ(NUM_REQ)) bus();
`ifdef ALU_SCHED_PERF_EN
  logic [31:0] perf_done;
  logic [15:0] perf_cas_fail;
  alu_cmd_scheduler #(.NUM_REQ(NUM_REQ)) dut (.clk(clk), .rst(rst), .bus(bus), .perf_done(perf_done), .perf_cas_fail(perf_cas_fail));
`else
  alu_cmd_scheduler #(.NUM_REQ(NUM_REQ)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif
  always #5 clk = ~clk;

  // ALU: returns {C, O, y}
  function automatic logic [33:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic o;
    s = '0;
    o = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; o = (a[31] == b[31]) && (s[31] != a[31]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; o = (a[31] != b[31]) && (s[31] != a[31]); end
      3'd2: s = {1'b0, a & b};
      3'd3: s = {1'b0, a | b};
      3'd4: s = {1'b0, a ^ b};
      3'd5: s = {a, 1'b0};
      3'd6: s = {1'b0, a} + 33'd1;
      default: s = '0;
    endcase
    return {s[32], o, s[31:0]};
  endfunction
  assign {bus.C, bus.O, bus.y} = alu_f(bus.alu_op_code, bus.data_a, bus.data_b);
  assign bus.Z = bus.y == 32'd0;
  assign bus.N = bus.y[31];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] mk(input logic [2:0] op, input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] a3);
    return {op, a1, a2, a3};
  endfunction

  // Model: register file plus the one in-flight transaction, ph = cycles since accept
  logic [31:0] m_r [8];
  int ph = -1, mptr = NUM_REQ - 1, g, last, e_id;
  logic [11:0] c;
  logic [2:0] e_op, e_dst;
  logic [31:0] e_a, e_b, e_data;
  logic [33:0] res;
  logic [3:0] e_fl;
  logic e_cas = 1'b0, e_ok;
  logic [NUM_REQ-1:0] exp_rdy;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_alu_op", 32'(bus.alu_op_code), 32'd0);
      chk("rst_data_a", bus.data_a, 32'd0);
      chk("rst_data_b", bus.data_b, 32'd0);
      ph = -1;
      mptr = NUM_REQ - 1;
      for (int k = 0; k < 8; k++) m_r[k] = '0;
    end else begin
      exp_rdy = '0;
      g = -1;
      if (ph < 0)
        for (int k = 1; k <= NUM_REQ; k++)
          if (g < 0 && bus.req_valid[(mptr + k) % NUM_REQ]) g = (mptr + k) % NUM_REQ;
      if (g >= 0) exp_rdy[g] = 1'b1;
      last = e_cas ? 3 : 2;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("busy", 32'(bus.busy), 32'(ph >= 1));
      chk("alu_op", 32'(bus.alu_op_code), ph == 1 ? 32'(e_op) : 32'd0);
      chk("data_a", bus.data_a, ph == 1 ? e_a : 32'd0);
      chk("data_b", bus.data_b, ph == 1 ? e_b : 32'd0);
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(ph == last));
      if (ph == last) begin
        chk("rsp_id", 32'(bus.rsp_id), 32'(e_id));
        chk("rsp_data", bus.rsp_data, e_data);
        chk("rsp_flags", 32'(bus.rsp_flags), 32'(e_fl));
        chk("rsp_cas_ok", 32'(bus.rsp_cas_ok), 32'(e_ok));
        m_r[e_dst] = e_data;
        if (e_cas) m_r[7] = {31'b0, e_ok};
        ph = -1;
      end else if (ph >= 1) ph++;
      if (g >= 0) begin
        c = bus.req_cmd[12*g +: 12];
        e_cas = c[11:9] == CAS;
        e_id = g;
        e_a = m_r[c[8:6]];
        if (e_cas) begin
          e_op = SUB;
          e_b = m_r[c[2:0]];
          e_ok = e_a == e_b;
          e_data = e_ok ? m_r[c[5:3]] : e_a;
          e_dst = e_ok ? c[8:6] : c[2:0];
        end else begin
          e_op = c[11:9];
          e_b = m_r[c[5:3]];
          e_ok = 1'b0;
          e_dst = c[2:0];
        end
        res = alu_f(e_op, e_a, e_b);
        if (!e_cas) e_data = res[31:0];
        e_fl = {res[32], res[33], res[31:0] == 32'd0, res[31]};
        ph = 1;
        mptr = g;
      end
    end
  end

  task automatic send(input int i, input logic [11:0] cm);
    int k;
    bus.req_cmd[12*i +: 12] = cm;
    bus.req_valid[i] = 1'b1;
    for (k = 0; k < 30; k++) begin
      @(negedge clk);
      if (bus.req_ready[i]) break;
    end
    gk = k;
    gv = bus.req_ready;
    chk("accept", 32'(bus.req_ready[i]), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp();
    lat = 0;
    rd = '0;
    rok = 1'b0;
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin
        lat = k;
        rd = bus.rsp_data;
        rok = bus.rsp_cas_ok;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int i, input logic [11:0] cm);
    send(i, cm);
    wait_rsp();
  endtask

  task automatic load(input logic [2:0] d, input logic [3:0] v);
    run(0, mk(XOR, d, d, d));
    for (int b = 3; b >= 0; b--) begin
      run(0, mk(SHL, d, 3'd0, d));
      if (v[b]) run(0, mk(INC, d, 3'd0, d));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_cmd = '0;
    do_reset();
    // Fairness: all four valid continuously
    for (int i = 0; i < NUM_REQ; i++) bus.req_cmd[12*i +: 12] = mk(INC, 3'(i), 3'd0, 3'(4 + i));
    bus.req_valid = '1;
    n = 0;
    for (int k = 0; k < 60 && n < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_ready[i]) begin
          order[n] = i;
          n++;
        end
    end
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    repeat (5) @(posedge clk);
    #1;
    chk("rr_count", 32'(n), 32'd5);
    for (int k = 0; k < 5; k++) chk("rr_order", 32'(order[k]), 32'(k % 4));
    // Plain add: 5 + 3
    do_reset();
    load(3'd1, 4'd5);
    load(3'd2, 4'd3);
    send(0, mk(ADD, 3'd1, 3'd2, 3'd3));
    chk("add_grant", 32'(gv), 32'h1);
    wait_rsp();
    chk("add_lat", 32'(lat), 32'd2);
    chk("add_data", rd, 32'd8);
    run(0, mk(ORR, 3'd3, 3'd3, 3'd4));
    chk("r3_after_add", rd, 32'd8);
    // CAS success
    load(3'd1, 4'd7);
    load(3'd2, 4'd9);
    load(3'd3, 4'd7);
    run(0, mk(CAS, 3'd1, 3'd2, 3'd3));
    chk("cas_ok_lat", 32'(lat), 32'd3);
    chk("cas_ok_flag", 32'(rok), 32'd1);
    chk("cas_ok_data", rd, 32'd9);
    run(0, mk(ORR, 3'd1, 3'd1, 3'd4));
    chk("cas_ok_r1", rd, 32'd9);
    run(0, mk(ORR, 3'd7, 3'd7, 3'd4));
    chk("cas_ok_r7", rd, 32'd1);
    // CAS fail with a competing requester raised mid-CAS
    load(3'd1, 4'd4);
    load(3'd3, 4'd7);
    send(0, mk(CAS, 3'd1, 3'd2, 3'd3));
    bus.req_cmd[12 +: 12] = mk(ORR, 3'd3, 3'd3, 3'd5);
    bus.req_valid[1] = 1'b1;
    wait_rsp();
    chk("cas_fail_lat", 32'(lat), 32'd3);
    chk("cas_fail_flag", 32'(rok), 32'd0);
    chk("cas_fail_data", rd, 32'd4);
    send(1, mk(ORR, 3'd3, 3'd3, 3'd5));
    chk("req1_after_rsp", 32'(gk), 32'd0);
    wait_rsp();
    chk("cas_fail_r3", rd, 32'd4);
    run(0, mk(ORR, 3'd1, 3'd1, 3'd6));
    chk("cas_fail_r1", rd, 32'd4);
    run(0, mk(ORR, 3'd7, 3'd7, 3'd6));
    chk("cas_fail_r7", rd, 32'd0);
    // a1 == a3 always succeeds; then non-CAS write to R7
    run(0, mk(CAS, 3'd2, 3'd5, 3'd2));
    chk("cas_same_ok", 32'(rok), 32'd1);
    chk("cas_same_data", rd, 32'd4);
    run(0, mk(INC, 3'd7, 3'd0, 3'd7));
    chk("r7_normal_write", rd, 32'd2);
    // Reset while in CAS_FLAG
    load(3'd1, 4'd5);
    load(3'd3, 4'd5);
    send(0, mk(CAS, 3'd1, 3'd2, 3'd3));
    repeat (2) @(posedge clk);
    #1;
    chk("in_cas_flag", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.req_cmd[12 +: 12] = mk(ORR, 3'd1, 3'd1, 3'd5);
    bus.req_valid[1] = 1'b1;
    send(0, mk(ORR, 3'd7, 3'd7, 3'd6));
    chk("post_rst_grant", 32'(gv), 32'h1);
    wait_rsp();
    chk("post_rst_r7", rd, 32'd0);
    run(1, mk(ORR, 3'd1, 3'd1, 3'd5));
    chk("post_rst_r1", rd, 32'd0);
`ifdef ALU_SCHED_PERF_EN
    do_reset();
    run(0, mk(INC, 3'd1, 3'd0, 3'd1));
    run(0, mk(SHL, 3'd1, 3'd0, 3'd1));
    run(0, mk(XOR, 3'd0, 3'd0, 3'd0));
    run(0, mk(CAS, 3'd1, 3'd0, 3'd3));
    run(0, mk(CAS, 3'd1, 3'd0, 3'd4));
    repeat (2) @(posedge clk);
    #1;
    chk("perf_done", perf_done, 32'd5);
    chk("perf_cas_fail", 32'(perf_cas_fail), 32'd2);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
